// File: rtl/port_io.sv
// CPU port-bus slave: word RAM, TX FIFO, one-entry RX holding register and a cycle timer.
// Latency: reads land in portout one edge after portget; writes take effect at the strobe edge.
// Backpressure: a TX push while full is dropped and sets sticky overflow; rx_ready is low while RX holds a word.
module port_io #(
    parameter int                   WORD_SIZE     = 16,
    parameter int                   RAM_ADDR_BITS = 8,
    parameter int                   TX_DEPTH_LOG2 = 3,
    parameter logic [WORD_SIZE-1:0] IO_BASE       = 16'hFF00
) (
    input  logic                 clk,
    input  logic                 do_reset_n,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    output logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready
);
    localparam int RAM_DEPTH = 1 << RAM_ADDR_BITS;
    localparam int TX_DEPTH  = 1 << TX_DEPTH_LOG2;
    localparam int CNT_W     = TX_DEPTH_LOG2 + 1;

    localparam logic [WORD_SIZE-1:0] A_TX   = IO_BASE;
    localparam logic [WORD_SIZE-1:0] A_STAT = IO_BASE + WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] A_RX   = IO_BASE + WORD_SIZE'(2);
    localparam logic [WORD_SIZE-1:0] A_TMR  = IO_BASE + WORD_SIZE'(3);

    logic [WORD_SIZE-1:0]     r_ram    [RAM_DEPTH];
    logic [WORD_SIZE-1:0]     r_tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [TX_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]         r_tx_count;
    logic                     r_ovf;
    logic                     r_rx_full;
    logic [WORD_SIZE-1:0]     r_rx_data;
    logic [WORD_SIZE-1:0]     r_timer;
    logic [WORD_SIZE-1:0]     r_portout;

    logic                     w_is_ram, w_is_tx, w_is_stat, w_is_rx, w_is_tmr;
    logic [RAM_ADDR_BITS-1:0] w_ram_idx;
    logic                     w_tx_empty, w_tx_full, w_push, w_pop, w_rx_take;
    logic [3:0]               w_cnt_disp;
    logic [WORD_SIZE-1:0]     w_status;
    logic [WORD_SIZE-1:0]     w_rdata;

    assign w_is_ram  = (portaddr[WORD_SIZE-1:RAM_ADDR_BITS] == '0);
    assign w_ram_idx = portaddr[RAM_ADDR_BITS-1:0];
    assign w_is_tx   = (portaddr == A_TX);
    assign w_is_stat = (portaddr == A_STAT);
    assign w_is_rx   = (portaddr == A_RX);
    assign w_is_tmr  = (portaddr == A_TMR);

    // Full is taken from the registered count, so a same-edge pop never frees a slot for the push.
    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == CNT_W'(TX_DEPTH));
    assign w_push     = portset & w_is_tx & ~w_tx_full;
    assign w_pop      = ~w_tx_empty & tx_ready;
    assign w_rx_take  = portget & w_is_rx & r_rx_full;

    always_comb begin
        w_cnt_disp = (int'(r_tx_count) > 15) ? 4'hF : 4'(r_tx_count);
        w_status   = WORD_SIZE'({w_cnt_disp, r_rx_full, r_ovf, w_tx_full, w_tx_empty});
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_ram) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_is_stat) begin
            w_rdata = w_status;
        end else if (w_is_rx && r_rx_full) begin
            w_rdata = r_rx_data;
        end else if (w_is_tmr) begin
            w_rdata = r_timer;
        end
    end

    always_ff @(posedge clk) begin
        if (portset && w_is_ram) begin
            r_ram[w_ram_idx] <= portval;
        end
        if (w_push) begin
            r_tx_mem[r_wr_ptr] <= portval;
        end
    end

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_count <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
            if (portset && w_is_tx && w_tx_full) begin
                r_ovf <= 1'b1;
            end else if (portset && w_is_stat) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            r_rx_full <= 1'b0;
            r_rx_data <= '0;
        end else if (w_rx_take) begin
            r_rx_full <= 1'b0;
        end else if (rx_valid && !r_rx_full) begin
            r_rx_full <= 1'b1;
            r_rx_data <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            r_timer   <= '0;
            r_portout <= '0;
        end else begin
            r_timer <= (portset && w_is_tmr) ? portval : r_timer + 1'b1;
            if (portget) begin
                r_portout <= w_rdata;
            end
        end
    end

    assign portout  = r_portout;
    assign tx_data  = r_tx_mem[r_rd_ptr];
    assign tx_valid = ~w_tx_empty;
    assign rx_ready = ~r_rx_full;
endmodule

// File: tb/tb_port_io.sv
// Bench for port_io: queue-based reference model checked every cycle plus directed literal checks.
module tb_port_io;
    localparam logic [15:0] A_TX = 16'hFF00;
    localparam logic [15:0] A_ST = 16'hFF01;
    localparam logic [15:0] A_RX = 16'hFF02;
    localparam logic [15:0] A_TM = 16'hFF03;

    logic        clk        = 1'b0;
    logic        do_reset_n = 1'b0;
    logic [15:0] portaddr   = 16'h0;
    logic [15:0] portval    = 16'h0;
    logic        portget    = 1'b0;
    logic        portset    = 1'b0;
    logic [15:0] portout;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready   = 1'b0;
    logic [15:0] rx_data    = 16'h0;
    logic        rx_valid   = 1'b0;
    logic        rx_ready;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    port_io dut (
        .clk        (clk),
        .do_reset_n (do_reset_n),
        .portaddr   (portaddr),
        .portval    (portval),
        .portget    (portget),
        .portset    (portset),
        .portout    (portout),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, everything else as plain variables.
    logic [15:0] m_ram [256];
    logic [15:0] m_q [$];
    bit          m_ovf;
    bit          m_rx_full;
    logic [15:0] m_rx_data;
    logic [15:0] m_timer;
    logic [15:0] m_portout;
    logic [15:0] m_rd;
    bit          m_was_full;

    function automatic logic [15:0] m_status();
        int c;
        c = (m_q.size() > 15) ? 15 : m_q.size();
        return {8'h00, 4'(c), m_rx_full, m_ovf, m_q.size() == 8, m_q.size() == 0};
    endfunction

    always @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_rx_full = 1'b0;
            m_rx_data = 16'h0;
            m_timer   = 16'h0;
            m_portout = 16'h0;
        end else begin
            m_rd = 16'h0;
            if (portaddr < 16'd256)                    m_rd = m_ram[portaddr[7:0]];
            else if (portaddr == A_ST)                 m_rd = m_status();
            else if (portaddr == A_RX && m_rx_full)    m_rd = m_rx_data;
            else if (portaddr == A_TM)                 m_rd = m_timer;
            if (portget) m_portout = m_rd;
            m_was_full = (m_q.size() == 8);
            if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
            if (portset && portaddr == A_TX) begin
                if (m_was_full) m_ovf = 1'b1;
                else            m_q.push_back(portval);
            end
            if (portset && portaddr == A_ST) m_ovf = 1'b0;
            if (portget && portaddr == A_RX && m_rx_full) begin
                m_rx_full = 1'b0;
            end else if (!m_rx_full && rx_valid) begin
                m_rx_full = 1'b1;
                m_rx_data = rx_data;
            end
            m_timer = (portset && portaddr == A_TM) ? portval : m_timer + 16'd1;
            if (portset && portaddr < 16'd256) m_ram[portaddr[7:0]] = portval;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx_valid", 16'(tx_valid), 16'(m_q.size() != 0));
            if (m_q.size() != 0) check("model_tx_data", tx_data, m_q[0]);
            check("model_rx_ready", 16'(rx_ready), 16'(!m_rx_full));
            check("model_portout", portout, m_portout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] v);
        portaddr = a; portval = v; portset = 1'b1;
        tick();
        portset = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [15:0] d);
        portaddr = a; portget = 1'b1;
        tick();
        portget = 1'b0;
        d = portout;
    endtask

    task automatic cpu_rw(input logic [15:0] a, input logic [15:0] v, output logic [15:0] d);
        portaddr = a; portval = v; portget = 1'b1; portset = 1'b1;
        tick();
        portget = 1'b0; portset = 1'b0;
        d = portout;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [15:0] a;
        logic [15:0] b;
        repeat (2) tick();
        chk_en = 1'b1;
        check("rst_portout", portout, 16'h0000);
        check("rst_tx_valid", 16'(tx_valid), 16'h0000);
        check("rst_rx_ready", 16'(rx_ready), 16'h0001);
        do_reset_n = 1'b1;

        // RAM, boundaries, unmapped, read-before-write
        cpu_wr(16'h0005, 16'hBEEF);
        cpu_rd(16'h0005, d);  check("ram_rd_5", d, 16'hBEEF);
        cpu_rd(16'h1234, d);  check("unmapped_rd", d, 16'h0000);
        cpu_wr(16'h0000, 16'h0A0A);
        cpu_wr(16'h00FF, 16'hCAFE);
        cpu_wr(16'h0100, 16'hDEAD);
        cpu_rd(16'h00FF, d);  check("ram_rd_ff", d, 16'hCAFE);
        cpu_rd(16'h0000, d);  check("ram_no_alias", d, 16'h0A0A);
        cpu_rd(16'h0100, d);  check("ram_above_rd", d, 16'h0000);
        cpu_rw(16'h0005, 16'h1111, d); check("ram_rw_old", d, 16'hBEEF);
        cpu_rd(16'h0005, d);  check("ram_rw_new", d, 16'h1111);
        cpu_wr(16'hFF04, 16'hFFFF);
        cpu_rd(16'hFF04, d);  check("io_unmapped", d, 16'h0000);

        // TX fill and overflow
        for (int i = 1; i <= 8; i++) cpu_wr(A_TX, 16'(i));
        cpu_rd(A_ST, d);      check("stat_full", d, 16'h0082);
        cpu_wr(A_TX, 16'd9);
        cpu_rd(A_ST, d);      check("stat_ovf", d, 16'h0086);
        cpu_rd(A_TX, d);      check("tx_reg_rd", d, 16'h0000);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", 16'(tx_valid), 16'h0001);
            check("drain_data", tx_data, 16'(i));
            tick();
        end
        check("drain_empty", 16'(tx_valid), 16'h0000);
        cpu_wr(A_ST, 16'h0000);
        cpu_rd(A_ST, d);      check("stat_ovf_clr", d, 16'h0001);

        // push and pop on the same edge
        tx_ready = 1'b0;
        cpu_wr(A_TX, 16'h0011);
        check("push_empty_valid", 16'(tx_valid), 16'h0001);
        cpu_wr(A_TX, 16'h0022);
        cpu_wr(A_TX, 16'h0033);
        check("pp_head", tx_data, 16'h0011);
        tx_ready = 1'b1;
        cpu_wr(A_TX, 16'hAAAA);
        tx_ready = 1'b0;
        cpu_rd(A_ST, d);      check("pp_count3", d, 16'h0030);
        tx_ready = 1'b1;
        check("pp_2nd", tx_data, 16'h0022); tick();
        check("pp_3rd", tx_data, 16'h0033); tick();
        check("pp_4th", tx_data, 16'hAAAA); tick();
        check("pp_empty", 16'(tx_valid), 16'h0000);
        tx_ready = 1'b0;

        // RX holding register
        rx_data = 16'h1234; rx_valid = 1'b1;
        tick();
        check("rx_captured", 16'(rx_ready), 16'h0000);
        rx_data = 16'h5678;
        tick(); tick();
        rx_valid = 1'b0;
        cpu_rd(A_ST, d);      check("stat_rx_full", d, 16'h0009);
        cpu_rd(A_RX, d);      check("rx_rd1", d, 16'h1234);
        check("rx_ready_back", 16'(rx_ready), 16'h0001);
        cpu_rd(A_RX, d);      check("rx_rd2", d, 16'h0000);

        // timer load, wrap, spacing and read/write collision
        cpu_wr(A_TM, 16'hFFFE);
        tick(); tick();
        cpu_rd(A_TM, d);      check("tmr_wrap", d, 16'h0000);
        cpu_rd(A_TM, a);      check("tmr_a", a, 16'h0001);
        tick(); tick();
        cpu_rd(A_TM, b);      check("tmr_gap", b - a, 16'h0003);
        cpu_rw(A_TM, 16'h0100, d); check("tmr_rw_old", d, 16'h0005);
        cpu_rd(A_TM, d);      check("tmr_rw_new", d, 16'h0100);

        // asynchronous reset in the middle of activity
        for (int i = 0; i < 5; i++) cpu_wr(A_TX, 16'h0040 + 16'(i));
        rx_data = 16'h4242; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        cpu_rd(16'h0005, d);  check("pre_rst_rd", d, 16'h1111);
        #2;
        do_reset_n = 1'b0;
        portaddr = A_TX; portval = 16'h7777; portset = 1'b1;
        #1;
        check("arst_tx_valid", 16'(tx_valid), 16'h0000);
        check("arst_rx_ready", 16'(rx_ready), 16'h0001);
        check("arst_portout", portout, 16'h0000);
        tick();
        portset = 1'b0;
        do_reset_n = 1'b1;
        cpu_rd(A_TM, d);      check("tmr_restart", d, 16'h0000);
        cpu_rd(A_ST, d);      check("post_rst_stat", d, 16'h0001);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
